// File: rtl/key_schedule_engine_pkg.sv
// Shared types, constants and S-box for the AES key-schedule engine.
// Covers AES-128/192/256 through the key length NK.
package key_sched_pkg;

    typedef enum logic [1:0] {IDLE, GEN, WRITE, DONE} ks_state_t;

    // Index 0 is never used by the schedule; the tail pads the table so that
    // any 4-bit counter value has a defined entry.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    function automatic int NR_OF(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/key_schedule_engine_if.sv
// Control and round-key SRAM write port of the key-schedule engine.
// Handshake: mem_we holds with stable mem_addr/mem_wdata until a cycle where mem_ack is high; that edge completes the write.
interface key_schedule_engine_if #(
    parameter int NK     = 4,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [32*NK-1:0]  key_in;
    logic              busy;
    logic              done;
    logic              mem_we;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [127:0]      mem_wdata;

    modport master (
        input  start, key_in, mem_ack,
        output busy, done, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, key_in, mem_ack,
        input  busy, done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/key_schedule_engine_subword.sv
// Combinational AES SubWord: four parallel S-box lookups, one per byte.
module ks_subword
    import key_sched_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        for (int b = 0; b < 4; b++) begin
            y[8*b +: 8] = sbox(x[8*b +: 8]);
        end
    end
endmodule

// File: rtl/key_schedule_engine.sv
// AES key-schedule engine: expands an NK-word key into NR+1 round keys, one word
// per cycle, and writes each completed 128-bit round key to SRAM.
module key_schedule_engine
    import key_sched_pkg::*;
#(
    parameter int NK          = 4,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 16,
    parameter int ADDR_STRIDE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    key_schedule_engine_if.master        bus,
    output ks_state_t                    dbg_state
);
    localparam int NR = NR_OF(NK);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("key_schedule_engine: NK must be 4, 6 or 8");
    end

    ks_state_t         state_q, state_d;
    logic [5:0]        i_q;
    logic [3:0]        r_q;
    logic [2:0]        kpos_q;
    logic [3:0]        rc_q;
    logic [31:0]       win_q [NK];
    logic [31:0]       row_q [4];
    logic [ADDR_W-1:0] addr_q;

    logic [31:0] prev_w, sub_in, sub_out, t_w, new_w;
    logic        key_phase, row_full, last_row;

    // win_q[0] is w[i-NK] and win_q[NK-1] is w[i-1]; kpos_q/rc_q track i%NK and i/NK.
    assign prev_w    = win_q[NK-1];
    assign sub_in    = (kpos_q == 3'd0) ? {prev_w[7:0], prev_w[31:8]} : prev_w;
    assign key_phase = (i_q < 6'(NK));
    assign row_full  = (i_q[1:0] == 2'd3);
    assign last_row  = (r_q == 4'(NR));

    ks_subword u_subword (.x(sub_in), .y(sub_out));

    always_comb begin
        t_w = prev_w;
        if (kpos_q == 3'd0) begin
            t_w = sub_out ^ {24'h0, RCON[rc_q]};
        end else if (NK == 8 && kpos_q == 3'd4) begin
            t_w = sub_out;
        end
    end

    // During the key phase the window simply rotates, replaying the key words in order.
    assign new_w = key_phase ? win_q[0] : (win_q[0] ^ t_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.mem_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = GEN;
            end
            GEN: begin
                bus.busy = 1'b1;
                if (row_full) state_d = WRITE;
            end
            WRITE: begin
                bus.busy   = 1'b1;
                bus.mem_we = 1'b1;
                if (bus.mem_ack) state_d = last_row ? DONE : GEN;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            r_q    <= '0;
            kpos_q <= '0;
            rc_q   <= '0;
            addr_q <= '0;
            for (int j = 0; j < NK; j++) win_q[j] <= '0;
            for (int j = 0; j < 4; j++) row_q[j] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int j = 0; j < NK; j++) win_q[j] <= bus.key_in[32*j +: 32];
                        i_q    <= '0;
                        r_q    <= '0;
                        kpos_q <= '0;
                        rc_q   <= '0;
                        addr_q <= ADDR_W'(BASE_ADDR);
                    end
                end
                GEN: begin
                    for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
                    win_q[NK-1]      <= new_w;
                    row_q[i_q[1:0]]  <= new_w;
                    i_q              <= i_q + 6'd1;
                    if (kpos_q == 3'(NK - 1)) begin
                        kpos_q <= '0;
                        rc_q   <= rc_q + 4'd1;
                    end else begin
                        kpos_q <= kpos_q + 3'd1;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        r_q    <= r_q + 4'd1;
                        addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = {row_q[3], row_q[2], row_q[1], row_q[0]};
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_key_schedule_engine.sv
// Bench for key_schedule_engine: AES-128/192/256 instances, a GF(2^8)-derived
// reference schedule feeding an expected-row queue, and directed scenarios.
module tb_key_schedule_engine;
    import key_sched_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    key_schedule_engine_if #(.NK(4), .ADDR_W(16)) if4 ();
    key_schedule_engine_if #(.NK(6), .ADDR_W(16)) if6 ();
    key_schedule_engine_if #(.NK(8), .ADDR_W(16)) if8 ();
    ks_state_t st4, st6, st8;

    key_schedule_engine #(.NK(4)) d4 (.clk(clk), .rst(rst), .bus(if4), .dbg_state(st4));
    key_schedule_engine #(.NK(6)) d6 (.clk(clk), .rst(rst), .bus(if6), .dbg_state(st6));
    key_schedule_engine #(.NK(8)) d8 (.clk(clk), .rst(rst), .bus(if8), .dbg_state(st8));

    int           sel;
    logic         start_v;
    logic [255:0] key_v;
    logic         ack;
    int           ack_mode;
    int           ack_cnt;

    assign if4.start   = start_v && (sel == 0);
    assign if6.start   = start_v && (sel == 1);
    assign if8.start   = start_v && (sel == 2);
    assign if4.key_in  = key_v[127:0];
    assign if6.key_in  = key_v[191:0];
    assign if8.key_in  = key_v;
    assign if4.mem_ack = ack && (sel == 0);
    assign if6.mem_ack = ack && (sel == 1);
    assign if8.mem_ack = ack && (sel == 2);

    logic         mon_we, mon_busy, mon_done;
    logic [15:0]  mon_addr;
    logic [127:0] mon_data;
    ks_state_t    mon_state;

    always_comb begin
        mon_we = if4.mem_we; mon_busy = if4.busy; mon_done = if4.done;
        mon_addr = if4.mem_addr; mon_data = if4.mem_wdata; mon_state = st4;
        if (sel == 1) begin
            mon_we = if6.mem_we; mon_busy = if6.busy; mon_done = if6.done;
            mon_addr = if6.mem_addr; mon_data = if6.mem_wdata; mon_state = st6;
        end else if (sel == 2) begin
            mon_we = if8.mem_we; mon_busy = if8.busy; mon_done = if8.done;
            mon_addr = if8.mem_addr; mon_data = if8.mem_wdata; mon_state = st8;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sb_ref [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_ref(input logic [31:0] x);
        return {sb_ref[x[31:24]], sb_ref[x[23:16]], sb_ref[x[15:8]], sb_ref[x[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                mw[i] = key[32*i +: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0) begin
                    t = sub_ref({t[7:0], t[31:8]}) ^ {24'h0, rc};
                    rc = xtime(rc);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = sub_ref(t);
                end
                mw[i] = mw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] pack_key(input logic [31:0] k0, k1, k2, k3, k4, k5, k6, k7);
        return {bswap(k7), bswap(k6), bswap(k5), bswap(k4), bswap(k3), bswap(k2), bswap(k1), bswap(k0)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [143:0] exp_q[$];
    logic [127:0] got_rows [16];
    int           wr_cnt = 0;
    logic         hold_pend = 1'b0;
    logic [15:0]  hold_addr;
    logic [127:0] hold_data;

    always @(negedge clk) begin
        logic [143:0] e;
        if (ack_mode == 0) begin
            ack = 1'b1;
        end else if (!mon_we) begin
            ack = 1'b0;
            ack_cnt = -1;
        end else begin
            if (ack_cnt < 0) ack_cnt = $urandom_range(0, 5);
            else if (ack_cnt > 0) ack_cnt--;
            ack = (ack_cnt == 0);
        end
        if (rst || !mon_we) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_addr", 128'(mon_addr), 128'(hold_addr));
                check("hold_data", mon_data, hold_data);
            end
            if (ack) begin
                check("sb_has_entry", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 128'(mon_addr), 128'(e[143:128]));
                    check("wr_data", mon_data, e[127:0]);
                end
                got_rows[4'(mon_addr[7:4] - 4'd1)] = mon_data;
                wr_cnt++;
                hold_pend = 1'b0;
            end else begin
                hold_pend = 1'b1;
                hold_addr = mon_addr;
                hold_data = mon_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int s, input logic [255:0] key);
        int nk;
        nk = (s == 0) ? 4 : (s == 1) ? 6 : 8;
        sel   = s;
        key_v = key;
        model_expand(nk, key);
        for (int r = 0; r <= nk + 6; r++) begin
            exp_q.push_back({16'(16 + 16 * r), mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]});
        end
        start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (!mon_done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 128'(mon_done), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    logic [255:0] key128, key192, key256;
    int cyc, w0, n_we, k;

    initial begin
        sel = 0; start_v = 1'b0; key_v = '0; ack_mode = 0; ack = 1'b1; ack_cnt = -1;
        rst = 1'b1;
        build_sbox();
        key128 = pack_key(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0);
        key192 = pack_key(32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                          32'h62f8ead2, 32'h522c6b7b, 0, 0);
        key256 = pack_key(32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                          32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(mon_busy), 128'(0));
        check("rst_done", 128'(mon_done), 128'(0));
        check("rst_we", 128'(mon_we), 128'(0));
        check("rst_addr", 128'(mon_addr), 128'(0));
        check("rst_wdata", mon_data, 128'(0));
        check("rst_state", 128'(mon_state), 128'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // AES-128, ack tied high
        w0 = wr_cnt;
        do_start(0, key128);
        check("t1_busy_after_start", 128'(mon_busy), 128'(1));
        wait_done(200, cyc);
        check("t1_done_cycle", 128'(cyc), 128'(56));
        check("t1_writes", 128'(wr_cnt - w0), 128'(11));
        check("t1_w4", 128'(got_rows[1][31:0]), 128'(32'h17fefaa0));
        check("t1_row10", got_rows[10], {bswap(32'hb6630ca6), bswap(32'he13f0cc8),
                                         bswap(32'hc9ee2589), bswap(32'hd014f9a8)});
        @(posedge clk); #1;
        check("t1_done_pulse", 128'(mon_done), 128'(0));
        check("t1_busy_idle", 128'(mon_busy), 128'(0));
        check("t1_queue_empty", 128'(exp_q.size()), 128'(0));

        // AES-192
        w0 = wr_cnt;
        do_start(1, key192);
        wait_done(300, cyc);
        check("t2_done_cycle", 128'(cyc), 128'(66));
        check("t2_writes", 128'(wr_cnt - w0), 128'(13));
        check("t2_w51", 128'(got_rows[12][127:96]), 128'(bswap(32'h01002202)));
        check("t2_queue_empty", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;

        // AES-256
        w0 = wr_cnt;
        do_start(2, key256);
        wait_done(300, cyc);
        check("t3_done_cycle", 128'(cyc), 128'(76));
        check("t3_writes", 128'(wr_cnt - w0), 128'(15));
        check("t3_w59", 128'(got_rows[14][127:96]), 128'(bswap(32'h706c631e)));
        check("t3_queue_empty", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;

        // AES-128 with random ack delay 0-5
        ack_mode = 1;
        w0 = wr_cnt;
        do_start(0, key128);
        wait_done(1000, cyc);
        check("t4_writes", 128'(wr_cnt - w0), 128'(11));
        check("t4_queue_empty", 128'(exp_q.size()), 128'(0));
        ack_mode = 0;
        @(posedge clk); #1;

        // stray starts during GEN, WRITE and DONE
        w0 = wr_cnt;
        do_start(0, key128);
        cyc = 1;
        while (!mon_done && cyc < 200) begin
            start_v = (cyc == 3 || cyc == 5 || cyc == 30);
            @(posedge clk); #1;
            cyc++;
        end
        start_v = 1'b0;
        check("t5_done_seen", 128'(mon_done), 128'(1));
        check("t5_done_cycle", 128'(cyc), 128'(56));
        start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        check("t5_idle_state", 128'(mon_state), 128'(IDLE));
        check("t5_idle_busy", 128'(mon_busy), 128'(0));
        check("t5_writes", 128'(wr_cnt - w0), 128'(11));
        check("t5_queue_empty", 128'(exp_q.size()), 128'(0));
        w0 = wr_cnt;
        do_start(0, key128);
        wait_done(200, cyc);
        check("t5_restart_writes", 128'(wr_cnt - w0), 128'(11));
        @(posedge clk); #1;

        // reset during the write of row 5
        w0 = wr_cnt;
        do_start(0, key128);
        k = 0;
        while (!(mon_we && (wr_cnt - w0) == 5) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_reach_row5", 128'(mon_we), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_busy", 128'(mon_busy), 128'(0));
        check("t6_done", 128'(mon_done), 128'(0));
        check("t6_we", 128'(mon_we), 128'(0));
        check("t6_addr", 128'(mon_addr), 128'(0));
        check("t6_wdata", mon_data, 128'(0));
        check("t6_rows_left", 128'(exp_q.size()), 128'(6));
        exp_q.delete();
        rst = 1'b0;
        n_we = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mon_we) n_we++;
        end
        check("t6_no_we_after_rst", 128'(n_we), 128'(0));
        w0 = wr_cnt;
        do_start(0, key128);
        wait_done(200, cyc);
        check("t6_full_writes", 128'(wr_cnt - w0), 128'(11));
        check("t6_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
